// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer
// Sweeps every input vector of a small combinational unit, holds each one
// for SETTLE cycles, samples the unit output and compares it against a
// golden truth table. Reports a mismatch count, the first failing vector and
// an overall pass flag.
//
// Ports:
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset
//   start          begin a sweep (accepted only in IDLE)
//   abort          cancel a running sweep (APPLY/SAMPLE only)
//   vec_out        drives the unit inputs; vec_out[N_IN-1] is input a
//   y_in           output of the unit under control
//   busy           sweep in progress (APPLY, SAMPLE, DONE)
//   done           one-cycle pulse at sweep completion
//   pass           last completed sweep had zero mismatches
//   err_count      mismatch count, saturating at 2**N_IN
//   fail_valid     at least one mismatch recorded
//   first_fail_idx lowest vector index that mismatched
module truth_table_sequencer #(
  parameter int                    N_IN     = 3,
  parameter int                    SETTLE   = 1,
  parameter logic [(2**N_IN)-1:0]  EXPECTED = 8'b1001_0110
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            abort,
  output logic [N_IN-1:0] vec_out,
  input  logic            y_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            fail_valid,
  output logic [N_IN-1:0] first_fail_idx
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [N_IN:0] ERR_MAX     = {1'b1, {N_IN{1'b0}}};

  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

  state_t          state;
  logic [N_IN-1:0] idx;
  logic [CW-1:0]   settle_cnt;
  logic            mismatch;
  logic [N_IN:0]   err_next;

  // Score of the vector currently being sampled. err_next is the count
  // including this sample, so pass can be computed from the final count on
  // the same edge that enters DONE.
  always_comb begin
    mismatch = (y_in != EXPECTED[idx]);
    err_next = err_count;
    if (mismatch && (err_count != ERR_MAX)) begin
      err_next = err_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      idx            <= '0;
      settle_cnt     <= '0;
      vec_out        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      fail_valid     <= 1'b0;
      first_fail_idx <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // Results of the previous sweep are held here until a new start.
          if (start) begin
            state          <= APPLY;
            idx            <= '0;
            settle_cnt     <= '0;
            vec_out        <= '0;
            busy           <= 1'b1;
            pass           <= 1'b0;
            err_count      <= '0;
            fail_valid     <= 1'b0;
            first_fail_idx <= '0;
          end
        end

        APPLY: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (settle_cnt == SETTLE_LAST) begin
            state <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end

        SAMPLE: begin
          // Abort wins: the vector being sampled is not scored.
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            err_count <= err_next;
            if (mismatch && !fail_valid) begin
              first_fail_idx <= idx;
              fail_valid     <= 1'b1;
            end
            if (&idx) begin
              state <= DONE;
              done  <= 1'b1;
              pass  <= (err_next == '0);
            end else begin
              idx        <= idx + 1'b1;
              vec_out    <= idx + 1'b1;
              settle_cnt <= '0;
              state      <= APPLY;
            end
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb_truth_table_sequencer
// Self-checking bench for truth_table_sequencer. A 3-input XOR model (with
// optional injected faults) plays the unit under control. Expected vector
// timing and sweep results are queued when a sweep is launched and checked
// by independent monitors. A second instance runs with SETTLE=3.
module tb_truth_table_sequencer;

  typedef struct {
    int         cyc;
    logic [2:0] vec;
  } vec_exp_t;

  typedef struct {
    int         cyc;
    logic       pass;
    logic [3:0] err;
    logic       fv;
    logic [2:0] ffi;
  } res_exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start, abort, y;
  logic [2:0] vec;
  logic       busy, done, pass, fail_valid;
  logic [3:0] err_count;
  logic [2:0] first_fail_idx;

  logic       start2, y2;
  logic [2:0] vec2;
  logic       busy2, done2, pass2, fail_valid2;
  logic [3:0] err_count2;
  logic [2:0] first_fail_idx2;

  int cyc = 0;
  int fault_mode = 0;
  int checks = 0;
  int errors = 0;
  int s;
  int t;

  vec_exp_t vq[$];
  res_exp_t rq[$];
  vec_exp_t vq2[$];
  res_exp_t rq2[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Unit model: 0 = correct XOR, 1 = output inverted for vector 5,
  // 2 = stuck at 0.
  assign y  = (fault_mode == 2) ? 1'b0 : ((^vec) ^ ((fault_mode == 1) && (vec == 3'd5)));
  assign y2 = ^vec2;

  truth_table_sequencer #(.N_IN(3), .SETTLE(1), .EXPECTED(8'b1001_0110)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .vec_out(vec), .y_in(y), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_valid(fail_valid), .first_fail_idx(first_fail_idx)
  );

  truth_table_sequencer #(.N_IN(3), .SETTLE(3), .EXPECTED(8'b1001_0110)) dut_slow (
    .clk(clk), .reset_n(reset_n), .start(start2), .abort(1'b0),
    .vec_out(vec2), .y_in(y2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err_count2), .fail_valid(fail_valid2), .first_fail_idx(first_fail_idx2)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic waitUntil(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Launch a sweep on the main instance from a negedge. Pushes the expected
  // appearance cycle of the first n_vec vectors and, if requested, the
  // expected result at the done pulse (cycle s+17 for SETTLE=1).
  task automatic applyStimulus(input int mode, input int n_vec, input bit push_res,
                               input int e_err, input int e_fv, input int e_ffi,
                               output int s_out);
    vec_exp_t v;
    res_exp_t r;
    fault_mode = mode;
    s_out = cyc;
    for (int k = 0; k < n_vec; k++) begin
      v.cyc = s_out + 1 + k * 2;
      v.vec = 3'(k);
      vq.push_back(v);
    end
    if (push_res) begin
      r.cyc  = s_out + 17;
      r.pass = (e_err == 0);
      r.err  = 4'(e_err);
      r.fv   = 1'(e_fv);
      r.ffi  = 3'(e_ffi);
      rq.push_back(r);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Vector timing monitor, main instance.
  always @(negedge clk) begin
    while (vq.size() > 0 && vq[0].cyc <= cyc) begin
      if (vq[0].cyc == cyc) checkOutput($sformatf("vec_out[%0d]", vq[0].vec), vec, vq[0].vec);
      else checkOutput("vec_out missed", cyc, vq[0].cyc);
      void'(vq.pop_front());
    end
  end

  // Result monitor, main instance: every done pulse must match a queued sweep.
  always @(negedge clk) begin
    if (reset_n && done) begin
      if (rq.size() == 0) begin
        checkOutput("unexpected done", 1, 0);
      end else begin
        checkOutput("done cycle", cyc, rq[0].cyc);
        checkOutput("pass at done", pass, rq[0].pass);
        checkOutput("err_count at done", err_count, rq[0].err);
        checkOutput("fail_valid at done", fail_valid, rq[0].fv);
        checkOutput("first_fail_idx at done", first_fail_idx, rq[0].ffi);
        checkOutput("busy at done", busy, 1);
        void'(rq.pop_front());
      end
    end
  end

  // Vector timing monitor, SETTLE=3 instance.
  always @(negedge clk) begin
    while (vq2.size() > 0 && vq2[0].cyc <= cyc) begin
      if (vq2[0].cyc == cyc) checkOutput($sformatf("slow vec_out[%0d]", vq2[0].vec), vec2, vq2[0].vec);
      else checkOutput("slow vec_out missed", cyc, vq2[0].cyc);
      void'(vq2.pop_front());
    end
  end

  // Result monitor, SETTLE=3 instance.
  always @(negedge clk) begin
    if (reset_n && done2) begin
      if (rq2.size() == 0) begin
        checkOutput("slow unexpected done", 1, 0);
      end else begin
        checkOutput("slow done cycle", cyc, rq2[0].cyc);
        checkOutput("slow pass at done", pass2, rq2[0].pass);
        checkOutput("slow err_count at done", err_count2, rq2[0].err);
        void'(rq2.pop_front());
      end
    end
  end

  initial begin
    vec_exp_t v;
    res_exp_t r;
    reset_n = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    start2  = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("reset vec_out", vec, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset pass", pass, 0);
    checkOutput("reset err_count", err_count, 0);
    checkOutput("reset fail_valid", fail_valid, 0);
    checkOutput("reset first_fail_idx", first_fail_idx, 0);
    checkOutput("reset slow busy", busy2, 0);

    // Correct model; start on the first edge after reset release.
    reset_n = 1'b1;
    applyStimulus(0, 8, 1, 0, 0, 0, s);
    // Start held through DONE and the following IDLE cycle: only the IDLE
    // cycle may launch the next sweep.
    waitUntil(s + 17);
    start = 1'b1;
    @(negedge clk);
    checkOutput("pass held in idle", pass, 1);
    checkOutput("busy in idle after done", busy, 0);
    checkOutput("vec_out held in idle", vec, 7);

    // Back-to-back sweep, vector 5 inverted.
    applyStimulus(1, 8, 1, 1, 1, 5, s);
    waitUntil(s + 2);
    checkOutput("pass cleared while busy", pass, 0);
    checkOutput("busy during sweep", busy, 1);
    waitUntil(s + 18);

    // Stuck-at-0 model; starts while busy and during DONE are ignored.
    applyStimulus(2, 8, 1, 4, 1, 1, s);
    waitUntil(s + 8);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitUntil(s + 17);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checkOutput("start in done ignored", busy, 0);
    checkOutput("err_count held", err_count, 4);
    checkOutput("first_fail_idx held", first_fail_idx, 1);

    // Abort during SAMPLE of vector 2 (cycle 6): vector 2 is not scored.
    applyStimulus(2, 3, 0, 0, 0, 0, s);
    waitUntil(s + 6);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("busy after abort", busy, 0);
    checkOutput("done after abort", done, 0);
    @(negedge clk);
    checkOutput("partial err_count", err_count, 1);
    checkOutput("partial fail_valid", fail_valid, 1);
    checkOutput("partial first_fail_idx", first_fail_idx, 1);
    checkOutput("pass after abort", pass, 0);
    checkOutput("vec_out held after abort", vec, 2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    checkOutput("abort in idle busy", busy, 0);
    checkOutput("abort in idle err_count", err_count, 1);

    // Normal sweep after abort.
    applyStimulus(0, 8, 1, 0, 0, 0, s);
    waitUntil(s + 18);

    // Reset mid-sweep in cycle 9: vectors 1 and 2 already scored as failures.
    applyStimulus(2, 4, 0, 0, 0, 0, s);
    waitUntil(s + 9);
    checkOutput("err_count before reset", err_count, 2);
    checkOutput("busy before reset", busy, 1);
    reset_n = 1'b0;
    #1;
    checkOutput("async reset vec_out", vec, 0);
    checkOutput("async reset busy", busy, 0);
    checkOutput("async reset err_count", err_count, 0);
    checkOutput("async reset fail_valid", fail_valid, 0);
    checkOutput("async reset first_fail_idx", first_fail_idx, 0);
    checkOutput("async reset pass", pass, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("no resume busy", busy, 0);
    checkOutput("no resume vec_out", vec, 0);

    // SETTLE=3 instance: vectors every 4 cycles, done in cycle 33.
    t = cyc;
    for (int k = 0; k < 8; k++) begin
      v.cyc = t + 1 + k * 4;
      v.vec = 3'(k);
      vq2.push_back(v);
    end
    r.cyc  = t + 33;
    r.pass = 1'b1;
    r.err  = 4'd0;
    r.fv   = 1'b0;
    r.ffi  = 3'd0;
    rq2.push_back(r);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    waitUntil(t + 36);

    checkOutput("pending vector checks", vq.size(), 0);
    checkOutput("pending results", rq.size(), 0);
    checkOutput("slow pending vector checks", vq2.size(), 0);
    checkOutput("slow pending results", rq2.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
